alu_control_sequencer: RTL

ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/ir_decode.sv | 46 ++++
 rtl/alu_control_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the ALU control sequencer: the sequencer state
// encoding, instruction field bit positions, opcode constants and the bounds
// of the ALU-class opcode range.
// Optional feature macro used by consumers of this package: CTRL_MULDIV_EN.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7,
      HALT = 4'd8
   } state_e;

   // Instruction field bit positions
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   // ALU-class opcode range (inclusive) and multiply/divide opcodes
   localparam logic [4:0] ALU_OPC_LO = 5'b00011;
   localparam logic [4:0] ALU_OPC_HI = 5'b01011;
   localparam logic [4:0] OPC_MUL    = 5'b01111;
   localparam logic [4:0] OPC_DIV    = 5'b10000;

   function automatic logic opc_is_alu(input logic [4:0] opc);
      return (opc >= ALU_OPC_LO) && (opc <= ALU_OPC_HI);
   endfunction

endpackage

// File: rtl/ir_decode.sv
// -----------------------------------------------------------------------------
// ir_decode
// Purely combinational instruction decoder.
// Ports:
//   ir_i        in  32  instruction register contents
//   opcode_o    out  5  IR[31:27]
//   ra_o        out  4  IR[26:23] destination register
//   rb_o        out  4  IR[22:19] first source register
//   rc_o        out  4  IR[18:15] second source register
//   is_alu_o    out  1  opcode in the ALU-class range
//   is_muldiv_o out  1  opcode is MUL or DIV (only with CTRL_MULDIV_EN)
//   illegal_o   out  1  opcode not executable by the sequencer
// Macro: CTRL_MULDIV_EN makes MUL/DIV legal; otherwise is_muldiv_o is 0.
// -----------------------------------------------------------------------------
module ir_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output logic [4:0]  opcode_o,
   output logic [3:0]  ra_o,
   output logic [3:0]  rb_o,
   output logic [3:0]  rc_o,
   output logic        is_alu_o,
   output logic        is_muldiv_o,
   output logic        illegal_o
);

   // Low instruction bits carry no information for the sequencer
   logic unused_ir_low;
   assign unused_ir_low = ^ir_i[RC_LSB-1:0];

   assign opcode_o = ir_i[OPC_MSB:OPC_LSB];
   assign ra_o     = ir_i[RA_MSB:RA_LSB];
   assign rb_o     = ir_i[RB_MSB:RB_LSB];
   assign rc_o     = ir_i[RC_MSB:RC_LSB];
   assign is_alu_o = opc_is_alu(opcode_o);

`ifdef CTRL_MULDIV_EN
   assign is_muldiv_o = (opcode_o == OPC_MUL) || (opcode_o == OPC_DIV);
`else
   assign is_muldiv_o = 1'b0;
`endif

   assign illegal_o = !(is_alu_o || is_muldiv_o);

endmodule

// File: rtl/alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer
// Moore FSM issuing datapath control strobes for fetch (T0-T2) and
// register/ALU execution (T3-T6). Outputs depend only on the state register
// and IR, so Run and Mem_Ready never reach an output combinationally.
// Ports:
//   Clock, Clear (async active-high), Run, Mem_Ready, IR[31:0]   inputs
//   PC_Out, MDR_Out, ZLO_Out, ZHI_Out                           bus drives
//   PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In,
//   LO_In, HI_In                                                 load enables
//   IncPC, Read, Rout_En, Rin_En, Rout_Sel[3:0], Rin_Sel[3:0],
//   CONTROL[4:0], Halted                                         control
// Macro: CTRL_MULDIV_EN enables the MUL/DIV path (T6 and the HI/LO strobes);
// without it ZHI_Out, ZHI_In, LO_In and HI_In stay 0.
// -----------------------------------------------------------------------------
module alu_control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Run,
   input  logic        Mem_Ready,
   input  logic [31:0] IR,
   output logic        PC_Out,
   output logic        MDR_Out,
   output logic        ZLO_Out,
   output logic        ZHI_Out,
   output logic        PC_In,
   output logic        MDR_In,
   output logic        MAR_In,
   output logic        IR_In,
   output logic        Y_In,
   output logic        ZLO_In,
   output logic        ZHI_In,
   output logic        LO_In,
   output logic        HI_In,
   output logic        IncPC,
   output logic        Read,
   output logic        Rout_En,
   output logic        Rin_En,
   output logic [3:0]  Rout_Sel,
   output logic [3:0]  Rin_Sel,
   output logic [4:0]  CONTROL,
   output logic        Halted
);

   state_e     state_q, state_d;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_muldiv, illegal;

   ir_decode u_ir_decode (
      .ir_i        (IR),
      .opcode_o    (opcode),
      .ra_o        (ra),
      .rb_o        (rb),
      .rc_o        (rc),
      .is_alu_o    (is_alu),
      .is_muldiv_o (is_muldiv),
      .illegal_o   (illegal)
   );

   // State register; Clear forces IDLE without waiting for a clock edge
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d  = state_q;
      PC_Out   = 1'b0;
      MDR_Out  = 1'b0;
      ZLO_Out  = 1'b0;
      ZHI_Out  = 1'b0;
      PC_In    = 1'b0;
      MDR_In   = 1'b0;
      MAR_In   = 1'b0;
      IR_In    = 1'b0;
      Y_In     = 1'b0;
      ZLO_In   = 1'b0;
      ZHI_In   = 1'b0;
      LO_In    = 1'b0;
      HI_In    = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Rout_En  = 1'b0;
      Rin_En   = 1'b0;
      Rout_Sel = 4'd0;
      Rin_Sel  = 4'd0;
      CONTROL  = 5'b00000;
      Halted   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Run) state_d = T0;
            else     state_d = IDLE;
         end
         T0: begin
            PC_Out  = 1'b1;
            MAR_In  = 1'b1;
            IncPC   = 1'b1;
            ZLO_In  = 1'b1;
            state_d = T1;
         end
         T1: begin
            // Read/MDR_In are held for the whole memory wait
            ZLO_Out = 1'b1;
            PC_In   = 1'b1;
            Read    = 1'b1;
            MDR_In  = 1'b1;
            if (Mem_Ready) state_d = T2;
            else           state_d = T1;
         end
         T2: begin
            MDR_Out = 1'b1;
            IR_In   = 1'b1;
            state_d = T3;
         end
         T3: begin
            Rout_En  = 1'b1;
            Rout_Sel = rb;
            Y_In     = 1'b1;
            if (illegal) state_d = HALT;
            else         state_d = T4;
         end
         T4: begin
            Rout_En  = 1'b1;
            Rout_Sel = rc;
            ZLO_In   = 1'b1;
            CONTROL  = opcode;
`ifdef CTRL_MULDIV_EN
            ZHI_In   = is_muldiv;
`endif
            state_d  = T5;
         end
         T5: begin
            ZLO_Out = 1'b1;
            if (is_alu) begin
               Rin_En  = 1'b1;
               Rin_Sel = ra;
               state_d = Run ? T0 : IDLE;
            end else if (is_muldiv) begin
`ifdef CTRL_MULDIV_EN
               LO_In   = 1'b1;
               state_d = T6;
`else
               state_d = HALT;
`endif
            end else begin
               // IR changed under the sequencer; stop rather than guess
               state_d = HALT;
            end
         end
         T6: begin
`ifdef CTRL_MULDIV_EN
            ZHI_Out = 1'b1;
            HI_In   = 1'b1;
            state_d = Run ? T0 : IDLE;
`else
            state_d = IDLE;
`endif
         end
         HALT: begin
            Halted  = 1'b1;
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
